// File: rtl/lut_neuron_prog.sv
// -----------------------------------------------------------------------------
// lut_neuron_prog
// Runtime-programmable LUT neuron. A truth table arrives over a config stream
// and is stored in distributed RAM. After loading, the block serves lookups:
// an IN_BITS-wide concatenated input code selects one OUT_BITS-wide
// activation code. The table can be reloaded at any time without
// re-synthesis.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cfg_start  pulse: begin (re)load, table invalidated
//   cfg_valid  config word valid
//   cfg_ready  config word accepted when cfg_valid & cfg_ready
//   cfg_data   EPW entries, entry k in [k*OUT_BITS +: OUT_BITS], lowest address in LSBs
//   cfg_done   one-cycle pulse after the last word is written
//   in_valid   lookup request valid
//   in_ready   lookup accepted when in_valid & in_ready
//   in_addr    LUT address (concatenated input codes)
//   out_valid  result valid
//   out_ready  result consumed when out_valid & out_ready
//   out_data   table[in_addr]
//
// Optional feature, macro LUT_READBACK_EN:
//   rb_addr (in) / rb_data (out): registered table read, latency 1, any state.
// -----------------------------------------------------------------------------
module lut_neuron_prog #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int CFG_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  output logic                cfg_done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data
`ifdef LUT_READBACK_EN
  ,
  input  logic [IN_BITS-1:0]  rb_addr,
  output logic [OUT_BITS-1:0] rb_data
`endif
);

  localparam int DEPTH = 2 ** IN_BITS;
  localparam int EPW   = CFG_W / OUT_BITS;
  localparam int NW    = DEPTH * OUT_BITS / CFG_W;
  localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READY
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic                cfg_done_q, cfg_done_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] out_data_q, out_data_d;

  logic [OUT_BITS-1:0] table_mem [DEPTH];

  logic                cfg_accept;
  logic                in_accept;
  logic                last_word;
  logic [IN_BITS-1:0]  wr_base;

  // cfg_start takes priority: a word presented in the same cycle is refused.
  assign cfg_ready  = (state_q == ST_LOAD) && !cfg_start;
  assign cfg_accept = cfg_valid && cfg_ready;

  // One-deep output register: a new lookup may enter whenever the held
  // result is absent or leaving this cycle.
  assign in_ready   = (state_q == ST_READY) && (!out_valid_q || out_ready);
  assign in_accept  = in_valid && in_ready;

  assign last_word  = (wcnt_q == CNT_W'(NW - 1));
  assign wr_base    = IN_BITS'(wcnt_q) * IN_BITS'(EPW);

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    cfg_done_d  = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (cfg_start) begin
      state_d = ST_LOAD;
      wcnt_d  = '0;
    end else if (cfg_accept) begin
      if (last_word) begin
        state_d    = ST_READY;
        wcnt_d     = '0;
        cfg_done_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end

    // A pending result survives state changes until it is consumed.
    if (in_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = table_mem[in_addr];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      cfg_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      cfg_done_q  <= cfg_done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Table RAM has no reset; each accepted word fills EPW consecutive entries.
  always_ff @(posedge clk) begin
    if (cfg_accept) begin
      for (int k = 0; k < EPW; k++) begin
        table_mem[wr_base + IN_BITS'(k)] <= cfg_data[k*OUT_BITS +: OUT_BITS];
      end
    end
  end

  assign cfg_done  = cfg_done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef LUT_READBACK_EN
  logic [OUT_BITS-1:0] rb_data_q, rb_data_d;

  // Independent read port; touches no cfg or lookup state.
  always_comb begin
    rb_data_d = table_mem[rb_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_data_q <= '0;
    end else begin
      rb_data_q <= rb_data_d;
    end
  end

  assign rb_data = rb_data_q;
`endif

endmodule

// File: tb/tb_lut_neuron_prog.sv
// -----------------------------------------------------------------------------
// tb_lut_neuron_prog
// Self-checking bench for lut_neuron_prog. A reference table is updated as
// config words are accepted; each accepted lookup pushes its expected value
// into a queue that is popped when the DUT hands over a result.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_lut_neuron_prog;

  localparam int IN_BITS  = 8;
  localparam int OUT_BITS = 2;
  localparam int CFG_W    = 16;
  localparam int EPW      = 8;
  localparam int NW       = 32;
  localparam int DEPTH    = 256;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_start = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [CFG_W-1:0]    cfg_data = '0;
  logic                cfg_done;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_addr = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [OUT_BITS-1:0] out_data;
`ifdef LUT_READBACK_EN
  logic [IN_BITS-1:0]  rb_addr = '0;
  logic [OUT_BITS-1:0] rb_data;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int pop_cnt  = 0;

  logic [OUT_BITS-1:0] model [DEPTH];
  logic [OUT_BITS-1:0] exp_q [$];
  logic [OUT_BITS-1:0] mon_exp;

  lut_neuron_prog #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .CFG_W   (CFG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_data (cfg_data),
    .cfg_done (cfg_done),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef LUT_READBACK_EN
    ,
    .rb_addr  (rb_addr),
    .rb_data  (rb_data)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: pop first so a same-cycle push never matches itself.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        chk_cnt++;
        pop_cnt++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL scoreboard_underflow: got out_data=%0d with no lookup pending", out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (out_data !== mon_exp) begin
            $display("[TB] FAIL scoreboard_data: got %0d expected %0d", out_data, mon_exp);
          end else begin
            pass_cnt++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model[in_addr]);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load words first..n-1. mode 0: {8{w[1:0]}}, 1: all 2, 2: all 1, else all 3.
  task automatic load_words(input int n, input int mode, input bit do_start, input int first);
    logic [CFG_W-1:0] w_data;
    if (do_start) begin
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
    end
    for (int w = first; w < n; w++) begin
      case (mode)
        0:       w_data = {8{w[1:0]}};
        1:       w_data = 16'hAAAA;
        2:       w_data = 16'h5555;
        default: w_data = 16'hFFFF;
      endcase
      cfg_valid = 1'b1;
      cfg_data  = w_data;
      @(negedge clk);
      chk_cnt++;
      if (cfg_ready !== 1'b1 || cfg_done !== 1'b0) begin
        $display("[TB] FAIL load_handshake word %0d: got cfg_ready=%b cfg_done=%b expected 1/0",
                 w, cfg_ready, cfg_done);
      end else begin
        pass_cnt++;
      end
      for (int k = 0; k < EPW; k++) begin
        model[w*EPW + k] = w_data[k*OUT_BITS +: OUT_BITS];
      end
      step();
    end
    cfg_valid = 1'b0;
    if (n == NW) begin
      @(negedge clk);
      chk_cnt++;
      if (cfg_done !== 1'b1) begin
        $display("[TB] FAIL cfg_done_pulse: got %b expected 1", cfg_done);
      end else begin
        pass_cnt++;
      end
      step();
      @(negedge clk);
      chk_cnt++;
      if (cfg_done !== 1'b0 || cfg_ready !== 1'b0) begin
        $display("[TB] FAIL cfg_done_clear: got cfg_done=%b cfg_ready=%b expected 0/0",
                 cfg_done, cfg_ready);
      end else begin
        pass_cnt++;
      end
      step();
    end
  endtask

  task automatic do_lookup(input logic [IN_BITS-1:0] a);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_addr  = a;
    for (int t = 0; t < 20 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) accepted = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (!accepted) begin
      chk_cnt++;
      $display("[TB] FAIL lookup_timeout: addr %0d not accepted, in_ready=%b", a, in_ready);
    end
  endtask

  task automatic stream_all();
    int stalls;
    int pops_before;
    stalls      = 0;
    pops_before = pop_cnt;
    out_ready   = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      in_valid = 1'b1;
      in_addr  = IN_BITS'(a);
      @(negedge clk);
      if (in_ready !== 1'b1) stalls++;
      if (a == 0) begin
        chk_cnt++;
        if (out_valid !== 1'b0) $display("[TB] FAIL stream_idle_before: got out_valid=%b expected 0", out_valid);
        else pass_cnt++;
      end
      if (a == 1) begin
        chk_cnt++;
        if (out_valid !== 1'b1) $display("[TB] FAIL stream_latency: got out_valid=%b expected 1", out_valid);
        else pass_cnt++;
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1) $display("[TB] FAIL stream_last_result: got out_valid=%b expected 1", out_valid);
    else pass_cnt++;
    step();
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("[TB] FAIL stream_drain: got out_valid=%b expected 0", out_valid);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (stalls != 0 || (pop_cnt - pops_before) != DEPTH) begin
      $display("[TB] FAIL stream_throughput: got stalls=%0d results=%0d expected 0/%0d",
               stalls, pop_cnt - pops_before, DEPTH);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (cfg_ready !== 1'b0 || cfg_done !== 1'b0 || in_ready !== 1'b0 ||
        out_valid !== 1'b0 || out_data !== 2'd0) begin
      $display("[TB] FAIL reset_outputs: got cfg_ready=%b cfg_done=%b in_ready=%b out_valid=%b out_data=%0d expected all 0",
               cfg_ready, cfg_done, in_ready, out_valid, out_data);
    end else begin
      pass_cnt++;
    end
    step();
    rst_n     = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 16'hFFFF;
    @(negedge clk);
    chk_cnt++;
    if (cfg_ready !== 1'b0 || in_ready !== 1'b0) begin
      $display("[TB] FAIL idle_ignores_cfg: got cfg_ready=%b in_ready=%b expected 0/0", cfg_ready, in_ready);
    end else begin
      pass_cnt++;
    end
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_load();
    logic [IN_BITS-1:0]  addrs [4];
    logic [OUT_BITS-1:0] expv  [4];
    addrs = '{8'h00, 8'h08, 8'h1F, 8'hFF};
    expv  = '{2'd0, 2'd1, 2'd3, 2'd3};
    load_words(NW, 0, 1'b1, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_lookup(addrs[i]);
      @(negedge clk);
      chk_cnt++;
      if (out_valid !== 1'b1 || out_data !== expv[i]) begin
        $display("[TB] FAIL load_lookup addr %0h: got valid=%b data=%0d expected 1/%0d",
                 addrs[i], out_valid, out_data, expv[i]);
      end else begin
        pass_cnt++;
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    stream_all();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_addr   = 8'h08;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_first_accept: got in_ready=%b expected 1", in_ready);
    else pass_cnt++;
    step();
    in_addr = 8'h10;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 2'd1) begin
        $display("[TB] FAIL bp_hold cycle %0d: got in_ready=%b out_valid=%b out_data=%0d expected 0/1/1",
                 c, in_ready, out_valid, out_data);
      end else begin
        pass_cnt++;
      end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_release: got in_ready=%b expected 1", in_ready);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 2'd2) begin
      $display("[TB] FAIL bp_next_result: got valid=%b data=%0d expected 1/2", out_valid, out_data);
    end else begin
      pass_cnt++;
    end
    step();
  endtask

  task automatic test_restart();
    out_ready = 1'b0;
    do_lookup(8'h1F);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 2'd3 || in_ready !== 1'b0 || cfg_ready !== 1'b1) begin
      $display("[TB] FAIL pending_across_start: got out_valid=%b out_data=%0d in_ready=%b cfg_ready=%b expected 1/3/0/1",
               out_valid, out_data, in_ready, cfg_ready);
    end else begin
      pass_cnt++;
    end
    step();
    load_words(11, 2, 1'b0, 0);
    out_ready = 1'b1;
    step();
    load_words(NW, 1, 1'b1, 0);
    stream_all();
  endtask

  task automatic test_start_collision();
    load_words(2, 2, 1'b1, 0);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 16'hFFFF;
    @(negedge clk);
    chk_cnt++;
    if (cfg_ready !== 1'b0) $display("[TB] FAIL collision_ready: got cfg_ready=%b expected 0", cfg_ready);
    else pass_cnt++;
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    load_words(NW, 0, 1'b0, 0);
    stream_all();
  endtask

  task automatic test_reset_midload();
    load_words(5, 1, 1'b1, 0);
    cfg_valid = 1'b1;
    cfg_data  = 16'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (cfg_ready !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || cfg_done !== 1'b0) begin
      $display("[TB] FAIL midload_reset: got cfg_ready=%b in_ready=%b out_valid=%b cfg_done=%b expected all 0",
               cfg_ready, in_ready, out_valid, cfg_done);
    end else begin
      pass_cnt++;
    end
    exp_q.delete();
    cfg_valid = 1'b0;
    step();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_addr  = 8'h00;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
      $display("[TB] FAIL after_reset_idle: got in_ready=%b cfg_ready=%b expected 0/0", in_ready, cfg_ready);
    end else begin
      pass_cnt++;
    end
    step();
    in_valid = 1'b0;
    load_words(NW, 0, 1'b1, 0);
    out_ready = 1'b1;
    do_lookup(8'hFF);
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 2'd3) begin
      $display("[TB] FAIL reload_lookup: got valid=%b data=%0d expected 1/3", out_valid, out_data);
    end else begin
      pass_cnt++;
    end
    step();
  endtask

`ifdef LUT_READBACK_EN
  task automatic test_readback();
    rb_addr = 8'h05;
    load_words(1, 1, 1'b1, 0);
    step();
    @(negedge clk);
    chk_cnt++;
    if (rb_data !== 2'd2) $display("[TB] FAIL readback_during_load: got %0d expected 2", rb_data);
    else pass_cnt++;
    step();
    load_words(NW, 1, 1'b0, 1);
    rb_addr = 8'hFF;
    stream_all();
    @(negedge clk);
    chk_cnt++;
    if (rb_data !== 2'd2) $display("[TB] FAIL readback_ready: got %0d expected 2", rb_data);
    else pass_cnt++;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_backpressure();
    test_restart();
    test_start_collision();
    test_reset_midload();
`ifdef LUT_READBACK_EN
    test_readback();
`endif
    chk_cnt++;
    if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_drained: got %0d pending expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
